mcs4_addr_stack: RTL and testbench

// - Parametrised program-counter and return-address stack for MCS-4 family cores.
// - Generalises the fixed 4004 arrangement (PC plus 3 saved levels, silent circular overwrite).
// - Adds configurable depth (4040-style 8 levels), address width, selectable overflow policy,

---
 rtl/mcs4_addr_stack_if.sv | 30 +++
 rtl/mcs4_addr_stack.sv | 114 +++++++++++
 tb/tb_mcs4_addr_stack.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcs4_addr_stack_if.sv
// Command and status bundle between the MCS-4 instruction decoder and the address stack.
// The decoder drives commands and the debug select; the stack returns pc, depth and error status.
interface mcs4_addr_stack_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  localparam int LW = $clog2(DEPTH);

  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              err_clr;
  logic [LW-1:0]     dbg_level;
  logic [ADDR_W-1:0] pc;
  logic [LW-1:0]     depth_cnt;
  logic              ovf;
  logic              unf;
  logic              err;
  logic [ADDR_W-1:0] dbg_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, err_clr, dbg_level,
    input  pc, depth_cnt, ovf, unf, err, dbg_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, err_clr, dbg_level,
    output pc, depth_cnt, ovf, unf, err, dbg_addr
  );
endinterface

// File: rtl/mcs4_addr_stack.sv
// Program counter plus circular return-address stack for MCS-4 style cores, with
// selectable overflow policy (circular overwrite or strict reject) and a debug read port.
module mcs4_addr_stack #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 4,
  parameter int OVF_MODE = 0
) (
  input logic              clk,
  input logic              rst,
  mcs4_addr_stack_if.slave bus
);
  localparam int S    = DEPTH - 1;
  localparam int PW   = $clog2(DEPTH);
  localparam bit CIRC = (OVF_MODE == 0);

  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_JUMP  = 3'd2;
  localparam logic [2:0] OP_JPAGE = 3'd3;
  localparam logic [2:0] OP_CALL  = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;

  // Pointers wrap modulo S, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(S - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(S - 1) : p - 1'b1;
  endfunction

  function automatic logic [PW-1:0] rd_idx(input logic [PW-1:0] p, input logic [PW-1:0] k);
    int t;
    t = (int'(p) + 3 * S - 1 - int'(k)) % S;
    return PW'(t);
  endfunction

  logic [ADDR_W-1:0] mem [S];
  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     cnt;
  logic [PW-1:0]     wp;
  logic              ovf;
  logic              unf;
  logic              err;

  logic          full;
  logic          empty;
  logic          is_call;
  logic          is_ret;
  logic          ovf_set;
  logic          unf_set;
  logic [PW-1:0] wp_top;

  assign full    = (cnt == PW'(S));
  assign empty   = (cnt == '0);
  assign is_call = bus.cmd_valid && (bus.cmd_op == OP_CALL);
  assign is_ret  = bus.cmd_valid && (bus.cmd_op == OP_RET);
  assign ovf_set = is_call && full;
  assign unf_set = is_ret && empty;
  assign wp_top  = ptr_dec(wp);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      cnt <= '0;
      wp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < S; i++) mem[i] <= '0;
    end else begin
      ovf <= ovf_set;
      unf <= unf_set;
      // A new error event outranks a simultaneous clear.
      if (ovf_set || unf_set) err <= 1'b1;
      else if (bus.err_clr)   err <= 1'b0;

      if (bus.cmd_valid) begin
        case (bus.cmd_op)
          OP_INC:   pc <= pc + 1'b1;
          OP_JUMP:  pc <= bus.cmd_addr;
          OP_JPAGE: pc <= {pc[ADDR_W-1:8], bus.cmd_addr[7:0]};
          OP_CALL: begin
            if (!full || CIRC) begin
              mem[wp] <= pc;
              wp      <= ptr_inc(wp);
              pc      <= bus.cmd_addr;
              if (!full) cnt <= cnt + 1'b1;
            end
          end
          OP_RET: begin
            // Circular mode pops stale data on underflow so behaviour stays deterministic.
            if (!empty || CIRC) begin
              pc <= mem[wp_top];
              wp <= wp_top;
              if (!empty) cnt <= cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.dbg_addr = '0;
    if (bus.dbg_level < cnt) bus.dbg_addr = mem[rd_idx(wp, bus.dbg_level)];
  end

  assign bus.pc        = pc;
  assign bus.depth_cnt = cnt;
  assign bus.ovf       = ovf;
  assign bus.unf       = unf;
  assign bus.err       = err;
endmodule

// File: tb/tb_mcs4_addr_stack.sv
// Bench for mcs4_addr_stack: a DEPTH=4 circular and a DEPTH=8 strict instance share one
// command stream; a stack model is checked every cycle, plus hand-computed checkpoints.
module tb_mcs4_addr_stack;
  localparam logic [2:0] NOP = 3'd0, INC = 3'd1, JUMP = 3'd2, JPAGE = 3'd3, CALL = 3'd4, RET = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [11:0] cmd_addr = 12'h000;
  logic        err_clr = 1'b0;
  logic [2:0]  dbg_lvl = 3'd0;
  bit          armed = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mcs4_addr_stack_if #(.ADDR_W(12), .DEPTH(4)) if4 ();
  mcs4_addr_stack_if #(.ADDR_W(12), .DEPTH(8)) if8 ();

  assign if4.cmd_valid = cmd_valid;
  assign if4.cmd_op    = cmd_op;
  assign if4.cmd_addr  = cmd_addr;
  assign if4.err_clr   = err_clr;
  assign if4.dbg_level = dbg_lvl[1:0];
  assign if8.cmd_valid = cmd_valid;
  assign if8.cmd_op    = cmd_op;
  assign if8.cmd_addr  = cmd_addr;
  assign if8.err_clr   = err_clr;
  assign if8.dbg_level = dbg_lvl;

  mcs4_addr_stack #(.ADDR_W(12), .DEPTH(4), .OVF_MODE(0)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  mcs4_addr_stack #(.ADDR_W(12), .DEPTH(8), .OVF_MODE(1)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  // Model: index 0 = 3 saved levels circular, index 1 = 7 saved levels strict.
  int unsigned m_mem [2][8];
  int unsigned m_pc [2];
  int          m_wp [2];
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  bit          m_err [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  s;
      bit  circ;
      s    = (d == 0) ? 3 : 7;
      circ = (d == 0);
      if (rst) begin
        m_pc[d] = 0; m_wp[d] = 0; m_cnt[d] = 0;
        m_ovf[d] = 0; m_unf[d] = 0; m_err[d] = 0;
        for (int i = 0; i < 8; i++) m_mem[d][i] = 0;
      end else begin
        m_ovf[d] = 0;
        m_unf[d] = 0;
        if (cmd_valid) begin
          case (cmd_op)
            INC:   m_pc[d] = (m_pc[d] + 1) % 4096;
            JUMP:  m_pc[d] = cmd_addr;
            JPAGE: m_pc[d] = (m_pc[d] & 32'hF00) | (cmd_addr & 12'h0FF);
            CALL: begin
              if (m_cnt[d] == s) m_ovf[d] = 1;
              if (m_cnt[d] < s || circ) begin
                m_mem[d][m_wp[d]] = m_pc[d];
                m_wp[d] = (m_wp[d] + 1) % s;
                m_pc[d] = cmd_addr;
                if (m_cnt[d] < s) m_cnt[d]++;
              end
            end
            RET: begin
              if (m_cnt[d] == 0) m_unf[d] = 1;
              if (m_cnt[d] > 0 || circ) begin
                m_wp[d] = (m_wp[d] + s - 1) % s;
                m_pc[d] = m_mem[d][m_wp[d]];
                if (m_cnt[d] > 0) m_cnt[d]--;
              end
            end
            default: ;
          endcase
        end
        if (m_ovf[d] || m_unf[d]) m_err[d] = 1;
        else if (err_clr)          m_err[d] = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [31:0] pc, input logic [31:0] cnt,
                         input logic ovf, input logic unf, input logic err, input logic [31:0] dbg);
    int          s;
    int          k;
    int unsigned e_dbg;
    s = (d == 0) ? 3 : 7;
    k = (d == 0) ? int'(dbg_lvl[1:0]) : int'(dbg_lvl);
    e_dbg = (k >= m_cnt[d]) ? 0 : m_mem[d][(m_wp[d] + s - 1 - k) % s];
    chk($sformatf("d%0d_pc", d), pc, m_pc[d]);
    chk($sformatf("d%0d_depth", d), cnt, m_cnt[d]);
    chk($sformatf("d%0d_ovf", d), {31'd0, ovf}, {31'd0, m_ovf[d]});
    chk($sformatf("d%0d_unf", d), {31'd0, unf}, {31'd0, m_unf[d]});
    chk($sformatf("d%0d_err", d), {31'd0, err}, {31'd0, m_err[d]});
    chk($sformatf("d%0d_dbg%0d", d, k), dbg, e_dbg);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_dut(0, 32'(if4.pc), 32'(if4.depth_cnt), if4.ovf, if4.unf, if4.err, 32'(if4.dbg_addr));
      cmp_dut(1, 32'(if8.pc), 32'(if8.depth_cnt), if8.ovf, if8.unf, if8.err, 32'(if8.dbg_addr));
    end
  end

  task automatic step(input logic [2:0] op, input logic [11:0] addr);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state and full pc wrap
    @(posedge clk);
    #1;
    armed = 1'b1;
    rst   = 1'b0;
    chk("rst_pc4", 32'(if4.pc), 32'h000);
    chk("rst_depth8", 32'(if8.depth_cnt), 0);
    chk("rst_err4", {31'd0, if4.err}, 0);
    repeat (4095) step(INC, 12'h000);
    chk("inc_fff", 32'(if4.pc), 32'hFFF);
    step(INC, 12'h000);
    chk("inc_wrap4", 32'(if4.pc), 32'h000);
    chk("inc_wrap8", 32'(if8.pc), 32'h000);
    chk("inc_depth", 32'(if4.depth_cnt), 0);

    // Page-relative jump after crossing a page, then long jump
    step(JUMP, 12'h2FF);
    step(INC, 12'h000);
    step(JPAGE, 12'h034);
    chk("jpage", 32'(if4.pc), 32'h334);
    step(6, 12'h777);
    chk("op6_nop", 32'(if8.pc), 32'h334);
    step(JUMP, 12'hABC);
    chk("jump", 32'(if8.pc), 32'hABC);

    // Circular overflow / stale underflow on the 4-level instance
    step(JUMP, 12'h010);
    step(CALL, 12'h100);
    step(CALL, 12'h200);
    step(CALL, 12'h300);
    chk("call3_depth4", 32'(if4.depth_cnt), 3);
    step(CALL, 12'h400);
    chk("ovf4", {31'd0, if4.ovf}, 1);
    chk("ovf4_pc", 32'(if4.pc), 32'h400);
    chk("ovf4_depth", 32'(if4.depth_cnt), 3);
    chk("no_ovf8", {31'd0, if8.ovf}, 0);
    dbg_lvl = 3'd0; #1 chk("dbg4_l0", 32'(if4.dbg_addr), 32'h300);
    dbg_lvl = 3'd2; #1 chk("dbg4_l2", 32'(if4.dbg_addr), 32'h100);
    dbg_lvl = 3'd3; #1 chk("dbg8_l3", 32'(if8.dbg_addr), 32'h010);
    chk("dbg4_l3_empty", 32'(if4.dbg_addr), 32'h000);
    step(RET, 12'h000); chk("ret4_1", 32'(if4.pc), 32'h300);
    step(RET, 12'h000); chk("ret4_2", 32'(if4.pc), 32'h200);
    step(RET, 12'h000); chk("ret4_3", 32'(if4.pc), 32'h100);
    step(RET, 12'h000);
    chk("unf4", {31'd0, if4.unf}, 1);
    chk("unf4_stale_pc", 32'(if4.pc), 32'h300);
    chk("ret8_4", 32'(if8.pc), 32'h010);
    chk("err4_sticky", {31'd0, if4.err}, 1);

    // Strict mode fill / reject / drain on the 8-level instance
    do_reset();
    step(JUMP, 12'h050);
    for (int i = 1; i <= 7; i++) step(CALL, 12'(i * 256));
    chk("fill8_depth", 32'(if8.depth_cnt), 7);
    step(CALL, 12'h800);
    chk("ovf8", {31'd0, if8.ovf}, 1);
    chk("ovf8_pc_held", 32'(if8.pc), 32'h700);
    chk("ovf8_depth", 32'(if8.depth_cnt), 7);
    for (int i = 6; i >= 1; i--) begin
      step(RET, 12'h000);
      chk($sformatf("ret8_lifo%0d", i), 32'(if8.pc), 32'(i * 256));
    end
    step(RET, 12'h000);
    chk("ret8_last", 32'(if8.pc), 32'h050);
    step(RET, 12'h000);
    chk("unf8", {31'd0, if8.unf}, 1);
    chk("unf8_pc_held", 32'(if8.pc), 32'h050);

    // Set beats clear, then clear alone
    for (int i = 1; i <= 7; i++) step(CALL, 12'(i * 16));
    err_clr = 1'b1;
    step(CALL, 12'hFFF);
    err_clr = 1'b0;
    chk("err_set_wins", {31'd0, if8.err}, 1);
    err_clr = 1'b1;
    step(NOP, 12'h000);
    err_clr = 1'b0;
    chk("err_clr8", {31'd0, if8.err}, 0);
    chk("err_clr4", {31'd0, if4.err}, 0);

    // Reset overrides a simultaneous CALL and drops saved levels
    step(JUMP, 12'h020);
    step(CALL, 12'h100);
    step(CALL, 12'h200);
    rst = 1'b1;
    step(CALL, 12'h300);
    rst = 1'b0;
    chk("rst_call_pc", 32'(if8.pc), 32'h000);
    chk("rst_call_depth", 32'(if8.depth_cnt), 0);
    for (int k = 0; k < 8; k++) begin
      dbg_lvl = 3'(k);
      #1 chk($sformatf("rst_dbg8_l%0d", k), 32'(if8.dbg_addr), 32'h000);
    end
    repeat (3) step(NOP, 12'h000);

    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
